// File: rtl/cl_mcl_pkg.sv
// Shared manycore-link definitions for the host request path.
//   HOST_REQ_MAX_CREDITS_p : default outstanding-request credit limit
//   bsg_mcl_request_s      : 128-bit request as seen by the link endpoint
//   mcl_pack_state_e       : packer FSM states
package cl_mcl_pkg;

  localparam int HOST_REQ_MAX_CREDITS_p = 16;

  // Field order mirrors the host word order: word0 at [31:0] ... word3 at [127:96].
  typedef struct packed {
    logic [15:0] padding;
    logic [15:0] addr_hi;
    logic [7:0]  op_ex;
    logic [7:0]  op;
    logic [15:0] addr_lo;
    logic [31:0] payload;
    logic [7:0]  x_cord;
    logic [7:0]  y_cord;
    logic [7:0]  src_x_cord;
    logic [7:0]  src_y_cord;
  } bsg_mcl_request_s;

  localparam int MCL_REQ_W = $bits(bsg_mcl_request_s);

  typedef enum logic {FILL = 1'b0, SEND = 1'b1} mcl_pack_state_e;

endpackage

// File: rtl/mcl_credit_counter.sv
// Up/down credit counter starting at max_p, saturating at both ends.
// A return (up) while full is dropped and sets a sticky overflow flag.
//   up_i       : one credit returned
//   down_i     : one credit consumed
//   count_o    : credits available
//   overflow_o : sticky, set by an up at max with no simultaneous down
module mcl_credit_counter #(
  parameter int max_p   = 16,
  parameter int width_p = $clog2(max_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o,
  output logic               overflow_o
);

  localparam logic [width_p-1:0] MAX_LP = width_p'(max_p);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_o    <= MAX_LP;
      overflow_o <= 1'b0;
    end else begin
      case ({up_i, down_i})
        2'b10: begin
          if (count_o == MAX_LP) overflow_o <= 1'b1;
          else                   count_o    <= count_o + 1'b1;
        end
        2'b01: if (count_o != '0) count_o <= count_o - 1'b1;
        default: ;  // none, or up and down cancel
      endcase
    end
  end

endmodule

// File: rtl/mcl_req_packer.sv
// Packs four host words into one bsg_mcl_request_s and issues it to the
// manycore link endpoint, gated by an outstanding-request credit count.
//   word_i/word_v_i/word_ready_o : host word stream, word0 lands in [31:0]
//   req_o/req_v_o/req_ready_i    : assembled request handshake
//   credit_return_i              : one request completed at the endpoint
//   credits_o                    : credits available (host credit register)
//   credit_overflow_o            : sticky, credit returned while full
// Optional (MCL_REQ_PACKER_STATS_EN):
//   sent_count_o   : fires, wrapping
//   stall_cycles_o : SEND cycles with no credit, saturating
module mcl_req_packer
  import cl_mcl_pkg::*;
#(
  parameter int max_credits_p   = HOST_REQ_MAX_CREDITS_p,
  parameter int credit_width_lp = $clog2(max_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [31:0]                word_i,
  input  logic                       word_v_i,
  output logic                       word_ready_o,
  output logic [MCL_REQ_W-1:0]       req_o,
  output logic                       req_v_o,
  input  logic                       req_ready_i,
  input  logic                       credit_return_i,
  output logic [credit_width_lp-1:0] credits_o,
`ifdef MCL_REQ_PACKER_STATS_EN
  output logic [31:0]                sent_count_o,
  output logic [31:0]                stall_cycles_o,
`endif
  output logic                       credit_overflow_o
);

  mcl_pack_state_e state_q, state_d;
  logic [1:0]      cnt_q;
  logic [3:0][31:0] req_q;
  logic            accept, fire, has_credit;

  assign has_credit = (credits_o != '0);
  assign accept     = word_v_i & word_ready_o;
  assign fire       = req_v_o & req_ready_i;
  assign req_o      = req_q;

  always_comb begin
    state_d      = state_q;
    word_ready_o = 1'b0;
    req_v_o      = 1'b0;
    case (state_q)
      FILL: begin
        word_ready_o = 1'b1;
        if (accept && cnt_q == 2'd3) state_d = SEND;
      end
      SEND: begin
        // Credits only rise while parked here, so valid never drops before fire.
        req_v_o = has_credit;
        if (fire) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= FILL;
      cnt_q   <= 2'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q[cnt_q] <= word_i;
        cnt_q        <= cnt_q + 2'd1;  // wraps to 0 on the 4th word
      end
    end
  end

  mcl_credit_counter #(
    .max_p   (max_credits_p),
    .width_p (credit_width_lp)
  ) u_credits (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .up_i       (credit_return_i),
    .down_i     (fire),
    .count_o    (credits_o),
    .overflow_o (credit_overflow_o)
  );

`ifdef MCL_REQ_PACKER_STATS_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sent_count_o   <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (fire) sent_count_o <= sent_count_o + 32'd1;
      if (state_q == SEND && !has_credit && stall_cycles_o != '1)
        stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mcl_req_packer.sv
module tb_mcl_req_packer;

  localparam int MAXC = 16;
  localparam int CW   = $clog2(MAXC + 1);

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic [31:0]   word_i = '0;
  logic          word_v_i = 1'b0;
  logic          word_ready_o;
  logic [127:0]  req_o;
  logic          req_v_o;
  logic          req_ready_i = 1'b0;
  logic          credit_return_i = 1'b0;
  logic [CW-1:0] credits_o;
  logic          credit_overflow_o;
`ifdef MCL_REQ_PACKER_STATS_EN
  logic [31:0]   sent_count_o, stall_cycles_o;
`endif

  mcl_req_packer #(.max_credits_p(MAXC)) dut (
    .clk_i             (clk_i),
    .reset_n_i         (reset_n_i),
    .word_i            (word_i),
    .word_v_i          (word_v_i),
    .word_ready_o      (word_ready_o),
    .req_o             (req_o),
    .req_v_o           (req_v_o),
    .req_ready_i       (req_ready_i),
    .credit_return_i   (credit_return_i),
    .credits_o         (credits_o),
`ifdef MCL_REQ_PACKER_STATS_EN
    .sent_count_o      (sent_count_o),
    .stall_cycles_o    (stall_cycles_o),
`endif
    .credit_overflow_o (credit_overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model: a packet is a list of collected words; a complete
  // packet waits for issue; credits are an integer count.
  int           m_cred;
  bit           m_ovf;
  bit           m_pend;
  logic [127:0] m_req;
  logic [31:0]  m_q[$];
  longint       m_sent, m_stall;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cred = MAXC; m_ovf = 0; m_pend = 0; m_req = '0; m_q.delete();
    m_sent = 0; m_stall = 0;
  endtask

  task automatic check_outputs();
    chk("word_ready", 128'(word_ready_o), 128'(!m_pend));
    chk("req_v", 128'(req_v_o), 128'(m_pend && m_cred > 0));
    if (m_pend) chk("req", req_o, m_req);
    chk("credits", 128'(credits_o), 128'(m_cred));
    chk("overflow", 128'(credit_overflow_o), 128'(m_ovf));
`ifdef MCL_REQ_PACKER_STATS_EN
    chk("sent_count", 128'(sent_count_o), 128'(m_sent[31:0]));
    chk("stall_cycles", 128'(stall_cycles_o), 128'(m_stall));
`endif
  endtask

  // Called at a negedge: check, drive, clock, advance the model.
  task automatic step(input logic v, input logic [31:0] w, input logic rdy, input logic ret);
    bit acc, fire;
    check_outputs();
    word_v_i = v; word_i = w; req_ready_i = rdy; credit_return_i = ret;
    acc  = v && !m_pend;
    fire = m_pend && m_cred > 0 && rdy;
    if (m_pend && m_cred == 0) m_stall++;
    @(posedge clk_i);
    if (fire) begin m_pend = 0; m_sent++; end
    if (fire && !ret) m_cred--;
    else if (ret && !fire) begin
      if (m_cred == MAXC) m_ovf = 1; else m_cred++;
    end
    if (acc) begin
      m_q.push_back(w);
      if (m_q.size() == 4) begin
        m_req  = {m_q[3], m_q[2], m_q[1], m_q[0]};
        m_pend = 1;
        m_q.delete();
      end
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0; word_v_i = 0; req_ready_i = 0; credit_return_i = 0;
    #1;
    model_reset();
    chk("rst_word_ready", 128'(word_ready_o), 128'(1));
    chk("rst_req_v", 128'(req_v_o), 128'(0));
    chk("rst_req", req_o, 128'(0));
    chk("rst_credits", 128'(credits_o), 128'(MAXC));
    chk("rst_overflow", 128'(credit_overflow_o), 128'(0));
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic pkt(input logic [31:0] w0, w1, w2, w3, input logic ret_on_fire);
    step(1, w0, 0, 0); step(1, w1, 0, 0); step(1, w2, 0, 0); step(1, w3, 0, 0);
    step(0, 32'h0, 1, ret_on_fire);
  endtask

  logic [127:0] exp_first;

  initial begin
    @(negedge clk_i);
    do_reset();

    // First packet: fixed words, exact assembly and credit decrement
    exp_first = 128'h00001234_00050403_DEADBEEF_01020304;
    step(1, 32'h01020304, 1, 0); step(1, 32'hDEADBEEF, 1, 0);
    step(1, 32'h00050403, 1, 0); step(1, 32'h00001234, 1, 0);
    chk("first_req", req_o, exp_first);
    chk("first_req_v", 128'(req_v_o), 128'(1));
    step(0, 32'h0, 1, 0);
    chk("first_req_v_drop", 128'(req_v_o), 128'(0));
    chk("first_credits", 128'(credits_o), 128'(15));

    // Drain all credits
    for (int i = 0; i < 15; i++) pkt($urandom, $urandom, $urandom, $urandom, 0);
    chk("drained_credits", 128'(credits_o), 128'(0));

    // 17th packet starves for 5 cycles, then one return lets it go
    step(1, $urandom, 1, 0); step(1, $urandom, 1, 0);
    step(1, $urandom, 1, 0); step(1, $urandom, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("starve_req_v", 128'(req_v_o), 128'(0));
      chk("starve_word_ready", 128'(word_ready_o), 128'(0));
      step(0, 32'h0, 1, 0);
    end
    step(0, 32'h0, 1, 1);
    chk("unstarve_req_v", 128'(req_v_o), 128'(1));
    step(0, 32'h0, 1, 0);
    chk("after_starve_credits", 128'(credits_o), 128'(0));
`ifdef MCL_REQ_PACKER_STATS_EN
    chk("stats_sent", 128'(sent_count_o), 128'(17));
    chk("stats_stall", 128'(stall_cycles_o), 128'(5));
`endif

    // Return coinciding with fire leaves credits unchanged
    for (int i = 0; i < 10; i++) step(0, 32'h0, 0, 1);
    chk("ten_credits", 128'(credits_o), 128'(10));
    pkt($urandom, $urandom, $urandom, $urandom, 1);
    chk("fire_plus_return", 128'(credits_o), 128'(10));

    // Fill to max, then overflow is sticky
    for (int i = 0; i < 6; i++) step(0, 32'h0, 0, 1);
    chk("full_credits", 128'(credits_o), 128'(16));
    step(0, 32'h0, 0, 1);
    chk("ovf_credits", 128'(credits_o), 128'(16));
    chk("ovf_set", 128'(credit_overflow_o), 128'(1));
    pkt($urandom, $urandom, $urandom, $urandom, 0);
    chk("ovf_sticky", 128'(credit_overflow_o), 128'(1));

    // Reset mid-packet discards partial words
    step(1, 32'hAAAA0001, 0, 0); step(1, 32'hAAAA0002, 0, 0);
    do_reset();
    step(1, 32'h11111111, 0, 0); step(1, 32'h22222222, 0, 0);
    step(1, 32'h33333333, 0, 0); step(1, 32'h44444444, 0, 0);
    chk("rst_mid_req", req_o, 128'h44444444_33333333_22222222_11111111);
    chk("rst_mid_credits", 128'(credits_o), 128'(16));
    step(0, 32'h0, 1, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
